// File: rtl/fpu_ss_issue_scoreboard_if.sv
// Issue-side bus of the FPU issue scoreboard: buffer head, FPnew issue
// request, commit/kill messages, writeback notifications and forwarding
// selects. The slave modport is the scoreboard; the master is its environment.
//
// Handshakes: the buffer head (pop_valid_i + payload) is held stable until
// pop_ready_o is high at a rising edge. An issue transfer happens on a cycle
// with fpu_in_valid_o & fpu_in_ready_i. fpu_in_valid_o may fall without a
// transfer when inputs change. Commit and writeback are one-cycle,
// always-accepted strobes.
interface fpu_ss_issue_scoreboard_if #(
  parameter int NUM_FPR  = 32,
  parameter int ID_WIDTH = 4
);
  localparam int RW = $clog2(NUM_FPR);

  logic                pop_valid_i;
  logic                pop_ready_o;
  logic [ID_WIDTH-1:0] in_id_i;
  logic [2:0][RW-1:0]  rs_i;
  logic [2:0]          rs_used_i;
  logic [RW-1:0]       rd_i;
  logic                rd_is_fp_i;
  logic                fpu_in_valid_o;
  logic                fpu_in_ready_i;
  logic                x_commit_valid_i;
  logic [ID_WIDTH-1:0] x_commit_id_i;
  logic                x_commit_kill_i;
  logic                wb_valid_i;
  logic [RW-1:0]       wb_rd_i;
  logic                wb_rd_is_fp_i;
  logic [2:0]          fwd_o;

  modport master (
    output pop_valid_i, in_id_i, rs_i, rs_used_i, rd_i, rd_is_fp_i,
           fpu_in_ready_i, x_commit_valid_i, x_commit_id_i, x_commit_kill_i,
           wb_valid_i, wb_rd_i, wb_rd_is_fp_i,
    input  pop_ready_o, fpu_in_valid_o, fwd_o
  );

  modport slave (
    input  pop_valid_i, in_id_i, rs_i, rs_used_i, rd_i, rd_is_fp_i,
           fpu_in_ready_i, x_commit_valid_i, x_commit_id_i, x_commit_kill_i,
           wb_valid_i, wb_rd_i, wb_rd_is_fp_i,
    output pop_ready_o, fpu_in_valid_o, fwd_o
  );
endinterface

// File: rtl/fpu_ss_issue_scoreboard.sv
// Issue/retire controller between the offload instruction buffer and FPnew.
// Tracks pending writes per FP register, gates issue on commit/kill status
// per transaction ID, detects RAW/WAW hazards with optional writeback
// forwarding, and drops killed instructions without issuing them.
module fpu_ss_issue_scoreboard #(
  parameter int NUM_FPR      = 32,
  parameter int ID_WIDTH     = 4,
  parameter int MAX_INFLIGHT = 4,
  parameter bit FORWARDING   = 1'b1,
  parameter bit WAW_ALLOWED  = 1'b1,
  localparam int RW  = $clog2(NUM_FPR),
  localparam int CW  = $clog2(MAX_INFLIGHT + 1),
  localparam int NID = 2 ** ID_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  fpu_ss_issue_scoreboard_if.slave bus,
  output logic                  kill_drop_o,
  output logic [CW-1:0]         inflight_cnt_o,
  output logic                  full_o,
  output logic                  err_o
);

  logic [CW-1:0]  pend_q [NUM_FPR];
  logic [CW-1:0]  pend_d [NUM_FPR];
  logic [CW-1:0]  inflight_q, inflight_d;
  logic [NID-1:0] committed_q, committed_d;
  logic [NID-1:0] killed_q, killed_d;
  logic           err_q, err_d;

  logic           same_id_commit;
  logic           com, kil;
  logic [2:0]     raw;
  logic           stall_rs, stall_rd, stall_cap;
  logic           full;
  logic           drop, issue_hs, issue_fp, wb_fp;

  // Release status of the head ID, hazard detection and issue/drop decision.
  always_comb begin
    same_id_commit = bus.x_commit_valid_i && (bus.x_commit_id_i == bus.in_id_i);
    com = committed_q[bus.in_id_i] | (same_id_commit & ~bus.x_commit_kill_i);
    kil = killed_q[bus.in_id_i]    | (same_id_commit &  bus.x_commit_kill_i);
    wb_fp = bus.wb_valid_i & bus.wb_rd_is_fp_i;

    raw       = '0;
    bus.fwd_o = '0;
    stall_rs  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      raw[k] = bus.rs_used_i[k] & (pend_q[bus.rs_i[k]] != '0);
      bus.fwd_o[k] = FORWARDING & raw[k] & wb_fp & (bus.wb_rd_i == bus.rs_i[k])
                     & (pend_q[bus.rs_i[k]] == CW'(1));
      stall_rs = stall_rs | (raw[k] & ~bus.fwd_o[k]);
    end

    // A writeback retiring the last pending write to rd releases the WAW stall.
    stall_rd = 1'b0;
    if (!WAW_ALLOWED) begin
      stall_rd = bus.rd_is_fp_i & (pend_q[bus.rd_i] != '0)
                 & ~(wb_fp & (bus.wb_rd_i == bus.rd_i) & (pend_q[bus.rd_i] == CW'(1)));
    end

    full      = (inflight_q == CW'(MAX_INFLIGHT));
    stall_cap = full & ~bus.wb_valid_i;

    // Kill wins over commit: a killed head is never offered to FPnew.
    drop               = bus.pop_valid_i & kil;
    bus.fpu_in_valid_o = bus.pop_valid_i & com & ~kil & ~stall_rs & ~stall_rd & ~stall_cap;
    issue_hs           = bus.fpu_in_valid_o & bus.fpu_in_ready_i;
    issue_fp           = issue_hs & bus.rd_is_fp_i;
    bus.pop_ready_o    = issue_hs | drop;
    kill_drop_o        = drop;
  end

  // Commit table: record commit/kill messages, clear the entry of a consumed head.
  always_comb begin
    committed_d = committed_q;
    killed_d    = killed_q;
    if (bus.x_commit_valid_i) begin
      if (bus.x_commit_kill_i) killed_d[bus.x_commit_id_i]    = 1'b1;
      else                     committed_d[bus.x_commit_id_i] = 1'b1;
    end
    // Applied after the set so a same-cycle commit to the consumed ID is absorbed.
    if (issue_hs || drop) begin
      committed_d[bus.in_id_i] = 1'b0;
      killed_d[bus.in_id_i]    = 1'b0;
    end
  end

  // Pending-write and in-flight counters with sticky underflow detection.
  always_comb begin
    pend_d     = pend_q;
    inflight_d = inflight_q;
    err_d      = err_q;
    for (int r = 0; r < NUM_FPR; r++) begin
      if (issue_fp && (bus.rd_i == RW'(r)) && !(wb_fp && (bus.wb_rd_i == RW'(r)))) begin
        pend_d[r] = pend_q[r] + CW'(1);
      end else if (wb_fp && (bus.wb_rd_i == RW'(r)) && !(issue_fp && (bus.rd_i == RW'(r)))) begin
        if (pend_q[r] == '0) err_d = 1'b1;
        else                 pend_d[r] = pend_q[r] - CW'(1);
      end
    end
    if (issue_hs && !bus.wb_valid_i) begin
      inflight_d = inflight_q + CW'(1);
    end else if (bus.wb_valid_i && !issue_hs) begin
      if (inflight_q == '0) err_d = 1'b1;
      else                  inflight_d = inflight_q - CW'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NUM_FPR; r++) pend_q[r] <= '0;
      inflight_q  <= '0;
      committed_q <= '0;
      killed_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      inflight_q  <= inflight_d;
      committed_q <= committed_d;
      killed_q    <= killed_d;
      err_q       <= err_d;
    end
  end

  assign inflight_cnt_o = inflight_q;
  assign full_o         = full;
  assign err_o          = err_q;

endmodule
